// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback result arbiter.
// Source codes are 1-based so that 3'b000 can mean "no result".
package wb_arb_pkg;

  typedef logic [2:0] src_code_t;

  localparam int unsigned NUM_SRC = 5;

  localparam src_code_t SRC_NONE = 3'b000;
  localparam src_code_t SRC_0    = 3'b001;
  localparam src_code_t SRC_1    = 3'b010;
  localparam src_code_t SRC_2    = 3'b011;
  localparam src_code_t SRC_3    = 3'b100;
  localparam src_code_t SRC_4    = 3'b101;

  function automatic src_code_t idx_to_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return SRC_0;
      3'd1:    return SRC_1;
      3'd2:    return SRC_2;
      3'd3:    return SRC_3;
      3'd4:    return SRC_4;
      default: return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational 5-way round-robin pick: first valid source at or after ptr,
// wrapping 4 -> 0.
module rr_pick5
  import wb_arb_pkg::*;
(
  input  logic [4:0] valid,
  input  logic [2:0] ptr,
  output logic [4:0] grant_oh,
  output logic [2:0] grant_idx,
  output logic       any
);

  logic       found;
  logic [2:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = 3'((32'(ptr) + k) % NUM_SRC);
      if (!found && valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_oh[grant_idx] = found;
  end

  assign any = |valid;

endmodule

// File: rtl/wb_result_arbiter.sv
// Round-robin arbiter feeding one output register for the 5-way writeback select.
// Optional per-source saturating grant counters under WB_ARB_STATS_EN.
module wb_result_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned N = 20
`ifdef WB_ARB_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             src_valid,
  input  logic [5*N-1:0]         src_data,
  output logic [4:0]             src_ready,
  output logic                   out_valid,
  output logic [N-1:0]           out_data,
  output src_code_t              out_sel,
  input  logic                   out_ready
`ifdef WB_ARB_STATS_EN
  , output logic [5*CNT_W-1:0]   grant_cnt
`endif
);

  logic            valid_q, valid_d;
  logic [N-1:0]    data_q, data_d;
  src_code_t       sel_q, sel_d;
  logic [2:0]      ptr_q, ptr_d;

  logic            load_en;
  logic [4:0]      grant_oh;
  logic [2:0]      grant_idx;
  logic            any;
  logic [N-1:0]    src_word [NUM_SRC];

  rr_pick5 u_pick (
    .valid     (src_valid),
    .ptr       (ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_word[i] = src_data[i*N +: N];
    end
  end

  assign load_en = !valid_q || out_ready;

  // rst_n gating keeps ready low during reset, when load_en is forced high.
  assign src_ready = grant_oh & {5{load_en && any && rst_n}};

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (any) begin
        valid_d = 1'b1;
        data_d  = src_word[grant_idx];
        sel_d   = idx_to_code(grant_idx);
        ptr_d   = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
      end else begin
        valid_d = 1'b0;
        sel_d   = SRC_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= SRC_NONE;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

`ifdef WB_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_d [NUM_SRC];

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (src_ready[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed self-checking bench for wb_result_arbiter; stats checks run only
// when WB_ARB_STATS_EN is defined.
module tb_wb_result_arbiter;

  logic          clk;
  logic          rst_n;
  logic [4:0]    src_valid;
  logic [99:0]   src_data;
  logic [4:0]    src_ready;
  logic          out_valid;
  logic [19:0]   out_data;
  logic [2:0]    out_sel;
  logic          out_ready;
  logic [19:0]   words [5];
`ifdef WB_ARB_STATS_EN
  logic [79:0]   grant_cnt;
`endif

  int tests_run;
  int tests_failed;

  assign src_data = {words[4], words[3], words[2], words[1], words[0]};

  wb_result_arbiter #(.N(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef WB_ARB_STATS_EN
    , .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n     = 1'b0;
    src_valid = '0;
    out_ready = 1'b0;
    words[0] = 20'h11111; words[1] = 20'h22222; words[2] = 20'h33333;
    words[3] = 20'h44444; words[4] = 20'h55555;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests_run++;
    if (out_sel !== 3'b000) begin tests_failed++; $display("FAIL reset_sel got %b exp 000", out_sel); end
    tests_run++;
    if (out_data !== 20'h0) begin tests_failed++; $display("FAIL reset_data got %h exp 00000", out_data); end
    src_valid = 5'b00001;
    out_ready = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_sel !== 3'b001) begin
      tests_failed++; $display("FAIL reset_preload got v=%b sel=%b exp v=1 sel=001", out_valid, out_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_sel !== 3'b000 || out_data !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset_mid got v=%b sel=%b data=%h exp v=0 sel=000 data=00000", out_valid, out_sel, out_data);
    end
    tests_run++;
    if (src_ready !== 5'b00000) begin tests_failed++; $display("FAIL reset_ready got %b exp 00000", src_ready); end
  endtask

  task automatic test_single();
    apply_reset();
    words[2]  = 20'hABCDE;
    src_valid = 5'b00100;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (src_ready !== 5'b00100) begin tests_failed++; $display("FAIL single_ready got %b exp 00100", src_ready); end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 20'hABCDE || out_sel !== 3'b011) begin
      tests_failed++;
      $display("FAIL single_out got v=%b data=%h sel=%b exp v=1 data=abcde sel=011", out_valid, out_data, out_sel);
    end
    src_valid = 5'b00000;
    #1;
    tests_run++;
    if (src_ready !== 5'b00000) begin tests_failed++; $display("FAIL single_idle_ready got %b exp 00000", src_ready); end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_sel !== 3'b000 || out_data !== 20'hABCDE) begin
      tests_failed++;
      $display("FAIL single_drain got v=%b sel=%b data=%h exp v=0 sel=000 data=abcde", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_all_valid();
    logic [4:0]  exp_rdy;
    logic [2:0]  exp_sel;
    logic [19:0] exp_data;
    apply_reset();
    src_valid = 5'b11111;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp_rdy  = 5'b00001 << (c % 5);
      exp_sel  = 3'((c % 5) + 1);
      exp_data = 20'(20'h11111 * ((c % 5) + 1));
      #1;
      tests_run++;
      if (src_ready !== exp_rdy) begin
        tests_failed++; $display("FAIL rr_ready[%0d] got %b exp %b", c, src_ready, exp_rdy);
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== exp_data) begin
        tests_failed++;
        $display("FAIL rr_out[%0d] got v=%b sel=%b data=%h exp v=1 sel=%b data=%h",
                 c, out_valid, out_sel, out_data, exp_sel, exp_data);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    src_valid = 5'b11111;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (src_ready !== 5'b00000) begin
        tests_failed++; $display("FAIL bp_ready[%0d] got %b exp 00000", c, src_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_sel !== 3'b001 || out_data !== 20'h11111) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d] got v=%b sel=%b data=%h exp v=1 sel=001 data=11111",
                 c, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (src_ready !== 5'b00010) begin tests_failed++; $display("FAIL bp_release_ready got %b exp 00010", src_ready); end
    @(posedge clk); #1;
    tests_run++;
    if (out_sel !== 3'b010 || out_data !== 20'h22222) begin
      tests_failed++; $display("FAIL bp_release_out got sel=%b data=%h exp sel=010 data=22222", out_sel, out_data);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    src_valid = 5'b10000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_sel !== 3'b101) begin tests_failed++; $display("FAIL wrap_first got sel=%b exp 101", out_sel); end
    src_valid = 5'b10001;
    #1;
    tests_run++;
    if (src_ready !== 5'b00001) begin tests_failed++; $display("FAIL wrap_ready0 got %b exp 00001", src_ready); end
    @(posedge clk); #1;
    tests_run++;
    if (out_sel !== 3'b001 || out_data !== 20'h11111) begin
      tests_failed++; $display("FAIL wrap_src0 got sel=%b data=%h exp sel=001 data=11111", out_sel, out_data);
    end
    #1;
    tests_run++;
    if (src_ready !== 5'b10000) begin tests_failed++; $display("FAIL wrap_ready4 got %b exp 10000", src_ready); end
    @(posedge clk); #1;
    tests_run++;
    if (out_sel !== 3'b101 || out_data !== 20'h55555) begin
      tests_failed++; $display("FAIL wrap_src4 got sel=%b data=%h exp sel=101 data=55555", out_sel, out_data);
    end
  endtask

`ifdef WB_ARB_STATS_EN
  task automatic test_stats();
    logic [79:0] exp_cnt;
    apply_reset();
    tests_run++;
    if (grant_cnt !== 80'h0) begin tests_failed++; $display("FAIL stats_reset got %h exp 0", grant_cnt); end
    src_valid = 5'b00010;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_cnt = 80'h0;
    exp_cnt[31:16] = 16'd3;
    tests_run++;
    if (grant_cnt !== exp_cnt) begin tests_failed++; $display("FAIL stats_count3 got %h exp %h", grant_cnt, exp_cnt); end
    repeat (65537) @(posedge clk);
    #1;
    exp_cnt[31:16] = 16'hFFFF;
    tests_run++;
    if (grant_cnt !== exp_cnt) begin tests_failed++; $display("FAIL stats_saturate got %h exp %h", grant_cnt, exp_cnt); end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_wrap();
`ifdef WB_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
